// File: rtl/guess_sweep_sched.sv
// Sweep controller for the CM-bus guessing protocol: issues one candidate
// byte per frame, times the MCU reply, retries on timeout and keeps the
// slowest-answered guess as the timing leak.
module guess_sweep_sched #(
  parameter logic [7:0] GUESS_FIRST = 8'h06,
  parameter logic [7:0] GUESS_LAST  = 8'hFF,
  parameter int         LAT_W       = 24,
  parameter int         TIMEOUT_CYC = 5_000_000,
  parameter int         MAX_RETRY   = 2
) (
  input  logic             CLK_50,
  input  logic             SW,
  input  logic             start,
  output logic             tx_req,
  output logic [7:0]       tx_byte,
  input  logic             tx_ack,
  input  logic             rx_valid,
  input  logic             rx_yes,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [7:0]       found_byte,
  output logic [7:0]       best_byte,
  output logic [LAT_W-1:0] best_lat,
  output logic [LAT_W-1:0] cur_lat,
  output logic             timeout_err
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, MEASURE, EVAL, FINISH} state_t;

  state_t           state_q, state_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [7:0]       found_byte_q, found_byte_d;
  logic [7:0]       best_byte_q, best_byte_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] cur_lat_q, cur_lat_d;
  logic [LAT_W-1:0] best_lat_q, best_lat_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             found_q, found_d;
  logic             terr_q, terr_d;
  logic             busy_q, busy_d;
  logic             yes_q, yes_d;
  logic             skip_q, skip_d;
  logic [LAT_W-1:0] cnt_inc;

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK_50) begin
    if (SW) begin
      state_q      <= IDLE;
      tx_byte_q    <= GUESS_FIRST;
      found_byte_q <= GUESS_FIRST;
      best_byte_q  <= GUESS_FIRST;
      cnt_q        <= '0;
      cur_lat_q    <= '0;
      best_lat_q   <= '0;
      retry_q      <= '0;
      found_q      <= 1'b0;
      terr_q       <= 1'b0;
      busy_q       <= 1'b0;
      yes_q        <= 1'b0;
      skip_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_byte_q    <= tx_byte_d;
      found_byte_q <= found_byte_d;
      best_byte_q  <= best_byte_d;
      cnt_q        <= cnt_d;
      cur_lat_q    <= cur_lat_d;
      best_lat_q   <= best_lat_d;
      retry_q      <= retry_d;
      found_q      <= found_d;
      terr_q       <= terr_d;
      busy_q       <= busy_d;
      yes_q        <= yes_d;
      skip_q       <= skip_d;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d      = state_q;
    tx_byte_d    = tx_byte_q;
    found_byte_d = found_byte_q;
    best_byte_d  = best_byte_q;
    cnt_d        = cnt_q;
    cur_lat_d    = cur_lat_q;
    best_lat_d   = best_lat_q;
    retry_d      = retry_q;
    found_d      = found_q;
    terr_d       = terr_q;
    busy_d       = busy_q;
    yes_d        = yes_q;
    skip_d       = skip_q;
    // cnt_q+1 is the latency as of the current edge, so a reply sampled k
    // edges after tx_ack reads as k
    cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ISSUE;
          tx_byte_d   = GUESS_FIRST;
          best_lat_d  = '0;
          best_byte_d = GUESS_FIRST;
          found_d     = 1'b0;
          terr_d      = 1'b0;
          retry_d     = '0;
          busy_d      = 1'b1;
          skip_d      = 1'b0;
        end
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_ack) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        cnt_d = cnt_inc;
        if (rx_valid) begin
          cur_lat_d = cnt_inc;
          yes_d     = rx_yes;
          skip_d    = 1'b0;
          state_d   = EVAL;
        end else if (cnt_inc >= LAT_W'(TIMEOUT_CYC)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ISSUE;
          end else begin
            terr_d  = 1'b1;
            retry_d = '0;
            yes_d   = 1'b0;
            skip_d  = 1'b1;
            state_d = EVAL;
          end
        end
      end
      EVAL: begin
        if (!skip_q && (cur_lat_q > best_lat_q)) begin
          best_lat_d  = cur_lat_q;
          best_byte_d = tx_byte_q;
        end
        if (yes_q && !skip_q) begin
          found_d      = 1'b1;
          found_byte_d = tx_byte_q;
          state_d      = FINISH;
        end else if (tx_byte_q == GUESS_LAST) begin
          state_d = FINISH;
        end else begin
          tx_byte_d = tx_byte_q + 1'b1;
          retry_d   = '0;
          state_d   = ISSUE;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_req      = (state_q == WAIT_ACK);
  assign done        = (state_q == FINISH);
  assign tx_byte     = tx_byte_q;
  assign busy        = busy_q;
  assign found       = found_q;
  assign found_byte  = found_byte_q;
  assign best_byte   = best_byte_q;
  assign best_lat    = best_lat_q;
  assign cur_lat     = cur_lat_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_guess_sweep_sched.sv
// Directed bench for guess_sweep_sched with a behavioural MCU/transmitter
// responder driven from per-byte latency / YES / silent tables.
module tb_guess_sweep_sched;

  logic        clk = 1'b0;
  logic        sw, start, tx_ack, rx_valid, rx_yes;
  logic        tx_req, busy, done, found, timeout_err;
  logic [7:0]  tx_byte, found_byte, best_byte;
  logic [23:0] best_lat, cur_lat;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned done_cnt = 0;
  logic        mcu_en = 1'b0;
  int unsigned lat_tab [256];
  bit          yes_tab [256];
  bit          silent_tab [256];
  logic [7:0]  req_log [$];

  guess_sweep_sched #(.TIMEOUT_CYC(100)) dut (
    .CLK_50(clk), .SW(sw), .start(start), .tx_req(tx_req), .tx_byte(tx_byte),
    .tx_ack(tx_ack), .rx_valid(rx_valid), .rx_yes(rx_yes), .busy(busy),
    .done(done), .found(found), .found_byte(found_byte), .best_byte(best_byte),
    .best_lat(best_lat), .cur_lat(cur_lat), .timeout_err(timeout_err)
  );

  always #10 clk = ~clk;

  // count done-high cycles, sampled mid-cycle
  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tables_default();
    for (int i = 0; i < 256; i++) begin
      lat_tab[i] = 10; yes_tab[i] = 1'b0; silent_tab[i] = 1'b0;
    end
  endtask

  // responder: acks each frame next edge, then replies lat_tab cycles later
  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (mcu_en && tx_req) begin
        b = tx_byte;
        req_log.push_back(b);
        tx_ack = 1'b1;
        @(posedge clk); #1;
        tx_ack = 1'b0;
        if (!silent_tab[b]) begin
          repeat (lat_tab[b] - 1) @(posedge clk);
          #1;
          rx_valid = 1'b1; rx_yes = yes_tab[b];
          @(posedge clk); #1;
          rx_valid = 1'b0; rx_yes = 1'b0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_sweep(input string tag, input int unsigned budget);
    bit seen;
    seen = 1'b0;
    req_log.delete();
    done_cnt = 0;
    pulse_start();
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    if (!seen) check({tag, "_done_seen"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned bad;
    sw = 1'b1; start = 1'b0; tx_ack = 1'b0; rx_valid = 1'b0; rx_yes = 1'b0;
    tables_default();
    repeat (3) @(posedge clk);
    #1 sw = 1'b0;
    @(posedge clk); #1;
    check("rst_tx_req", tx_req, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_byte", tx_byte, 8'h06);
    check("rst_best_byte", best_byte, 8'h06);
    check("rst_best_lat", best_lat, 0);

    // stray strobes in IDLE
    tx_ack = 1'b1; rx_valid = 1'b1; rx_yes = 1'b1;
    @(posedge clk); #1;
    tx_ack = 1'b0; rx_valid = 1'b0; rx_yes = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ign_busy", busy, 0);
    check("idle_ign_req", tx_req, 0);
    check("idle_ign_cur", cur_lat, 0);
    check("idle_ign_found", found, 0);

    // full NO sweep, 0x42 slow
    mcu_en = 1'b1;
    tables_default();
    lat_tab[8'h42] = 37;
    run_sweep("sweep", 20000);
    check("sweep_frames", req_log.size(), 250);
    bad = 0;
    foreach (req_log[i]) if (req_log[i] != 8'(6 + i)) bad++;
    check("sweep_order", bad, 0);
    check("sweep_done_cnt", done_cnt, 1);
    check("sweep_found", found, 0);
    check("sweep_best_byte", best_byte, 8'h42);
    check("sweep_best_lat", best_lat, 37);
    check("sweep_busy", busy, 0);

    // YES on 0x09 at latency 5
    tables_default();
    lat_tab[8'h09] = 5; yes_tab[8'h09] = 1'b1;
    run_sweep("yes", 2000);
    check("yes_frames", req_log.size(), 4);
    check("yes_found", found, 1);
    check("yes_found_byte", found_byte, 8'h09);
    check("yes_cur_lat", cur_lat, 5);
    check("yes_done_cnt", done_cnt, 1);
    check("yes_busy", busy, 0);
    check("yes_best_byte", best_byte, 8'h06);
    check("yes_best_lat", best_lat, 10);

    // silent 0x07: three sends, then skipped
    tables_default();
    silent_tab[8'h07] = 1'b1;
    lat_tab[8'h08] = 5; yes_tab[8'h08] = 1'b1;
    run_sweep("tmo", 4000);
    check("tmo_frames", req_log.size(), 5);
    bad = 0;
    if (req_log.size() == 5) begin
      if (req_log[0] != 8'h06) bad++;
      for (int i = 1; i < 4; i++) if (req_log[i] != 8'h07) bad++;
    end
    check("tmo_seq", bad, 0);
    check("tmo_next_byte", (req_log.size() > 4) ? req_log[4] : 8'h00, 8'h08);
    check("tmo_err", timeout_err, 1);
    check("tmo_best_byte", best_byte, 8'h06);
    check("tmo_best_lat", best_lat, 10);
    check("tmo_found_byte", found_byte, 8'h08);

    // tie at latency 20 keeps the first byte
    tables_default();
    lat_tab[8'h06] = 20; lat_tab[8'h0A] = 20;
    lat_tab[8'h0C] = 3; yes_tab[8'h0C] = 1'b1;
    run_sweep("tie", 2000);
    check("tie_best_byte", best_byte, 8'h06);
    check("tie_best_lat", best_lat, 20);
    check("tie_err_cleared", timeout_err, 0);
    check("tie_found_byte", found_byte, 8'h0C);

    // stray rx_valid and start while waiting for ack, then reset mid-frame
    mcu_en = 1'b0;
    tables_default();
    pulse_start();
    bad = 1;
    for (int i = 0; i < 20 && bad != 0; i++) begin
      @(posedge clk); #1;
      if (tx_req) bad = 0;
    end
    check("wa_req_seen", bad, 0);
    rx_valid = 1'b1; rx_yes = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_yes = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wa_req_held", tx_req, 1);
    check("wa_byte", tx_byte, 8'h06);
    check("wa_busy", busy, 1);
    check("wa_found", found, 0);
    sw = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_req", tx_req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_found_byte", found_byte, 8'h06);
    check("rst_mid_cur_lat", cur_lat, 0);
    check("rst_mid_best_lat", best_lat, 0);
    check("rst_mid_done", done, 0);
    sw = 1'b0;
    mcu_en = 1'b1;
    lat_tab[8'h06] = 4; yes_tab[8'h06] = 1'b1;
    run_sweep("restart", 1000);
    check("restart_first", (req_log.size() > 0) ? req_log[0] : 8'h00, 8'h06);
    check("restart_found_byte", found_byte, 8'h06);
    check("restart_cur_lat", cur_lat, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
